// File: rtl/muldiv_pkg.sv
// Shared encodings and default sizes for the MULTU/DIVU sequencer and its
// single-iteration arithmetic step.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared working register: shift-add for MULTU,
// restoring shift-subtract for DIVU. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  step_mode_e         mode,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] work_next
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] trial;

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    work_next = '0;
    sum       = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, operand} : '0);
    shl       = {work, 1'b0};
    // One extra bit beyond the shifted upper half keeps the borrow distinct
    // from data, so a zero divisor always yields a non-negative trial.
    trial     = {1'b0, shl[2*WIDTH:WIDTH]} - {2'b00, operand};

    if (mode == STEP_MUL) begin
      work_next = {sum, work[WIDTH-1:1]};
    end else if (!trial[WIDTH+1]) begin
      work_next = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      work_next = shl[2*WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU unit with HI/LO registers and a core stall output.
// Iterates muldiv_step 32 times, then commits the result in one edge.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state;
  state_e             state_next;
  op_e                op_dec;
  step_mode_e         mode;
  logic [CNT_W-1:0]   count;
  logic               last_iter;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   operand;

  assign op_dec    = op_e'(op);
  assign mode      = (state == S_DIV) ? STEP_DIV : STEP_MUL;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode      (mode),
    .work      (work),
    .operand   (operand),
    .work_next (work_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start && op_dec == OP_MULTU)     state_next = S_MUL;
        else if (start && op_dec == OP_DIVU) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (last_iter) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == S_MUL) || (state == S_DIV);
    done  = (state == S_DONE);
    stall = busy || ((state == S_IDLE) && start && !op[1]);
  end

  // HI/LO change only on a move in IDLE or on the final iteration's commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      work    <= '0;
      operand <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            unique case (op_dec)
              OP_MULTU: begin
                work    <= {{WIDTH{1'b0}}, b};
                operand <= a;
              end
              OP_DIVU: begin
                work    <= {{WIDTH{1'b0}}, a};
                operand <= b;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          work  <= work_next;
          count <= last_iter ? '0 : count + 1'b1;
          if (last_iter) begin
            hi <= work_next[2*WIDTH-1:WIDTH];
            lo <= work_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed scenarios plus random
// MULTU/DIVU/MTHI/MTLO traffic against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result {hi, lo} straight from unsigned arithmetic.
  function automatic logic [2*W-1:0] ref_result(input logic [1:0] rop,
                                                input logic [W-1:0] ra,
                                                input logic [W-1:0] rb);
    if (rop == OP_MULTU) return (2*W)'(ra) * (2*W)'(rb);
    if (rb == '0)        return {ra, {W{1'b1}}};
    return {ra % rb, ra / rb};
  endfunction

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      3:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  // Issues one MULTU/DIVU and observes it to completion.
  // inject: 0 none, 1 MTLO request at busy cycle 10, 2 MTHI request in DONE cycle.
  task automatic run_op(input logic [1:0] rop, input logic [W-1:0] ra, input logic [W-1:0] rb,
                        input int inject,
                        output logic stall_issue, output int busy_cycles,
                        output bit stall_gap, output bit hold_bad,
                        output logic done_end, output logic done_after, output logic busy_after,
                        output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                        output logic [W-1:0] hi_after);
    logic [W-1:0] hi0, lo0;
    busy_cycles = 0;
    stall_gap   = 0;
    hold_bad    = 0;
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = rop; a = ra; b = rb;
    #1 stall_issue = stall;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
      if (!stall) stall_gap = 1;
      if (hi !== hi0 || lo !== lo0 || done !== 1'b0) hold_bad = 1;
      if (inject == 1 && busy_cycles == 10) begin
        start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
      end
      if (inject == 1 && busy_cycles == 11) start = 1'b0;
    end
    done_end = done;
    rhi = hi;
    rlo = lo;
    if (inject == 2) begin
      start = 1'b1; op = OP_MTHI; a = 32'h5555_AAAA;
    end
    @(negedge clk);
    done_after = done;
    busy_after = busy;
    hi_after   = hi;
    start      = 1'b0;
  endtask

  // Issues one MTHI/MTLO and samples the cycle after the issue edge.
  task automatic do_move(input logic [1:0] rop, input logic [W-1:0] ra,
                         output logic stall_issue, output logic [2:0] flags_after,
                         output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    @(negedge clk);
    start = 1'b1; op = rop; a = ra; b = '0;
    #1 stall_issue = stall;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    flags_after = {busy, stall, done};
    rhi = hi;
    rlo = lo;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, stall} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {busy, done, stall});
    end
    checks++;
    if ({hi, lo} !== '0) begin
      errors++; $display("FAIL reset_hilo: got %h required 0", {hi, lo});
    end
    reset = 1'b0;
  endtask

  task automatic test_multu();
    logic [W-1:0] ta [2] = '{32'd7, 32'hFFFF_FFFF};
    logic [W-1:0] tb [2] = '{32'd6, 32'hFFFF_FFFF};
    logic st, de, da, ba; int bc; bit gap, hold;
    logic [W-1:0] rh, rl, ha;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      run_op(OP_MULTU, ta[i], tb[i], 0, st, bc, gap, hold, de, da, ba, rh, rl, ha);
      exp = ref_result(OP_MULTU, ta[i], tb[i]);
      checks++;
      if (st !== 1'b1) begin errors++; $display("FAIL multu%0d stall_issue: got %b required 1", i, st); end
      checks++;
      if (bc != 32) begin errors++; $display("FAIL multu%0d busy_cycles: got %0d required 32", i, bc); end
      checks++;
      if ({gap, hold} != 2'b00) begin
        errors++; $display("FAIL multu%0d busy_window gap/hold: got %b required 00", i, {gap, hold});
      end
      checks++;
      if ({de, da} !== 2'b10) begin errors++; $display("FAIL multu%0d done_pulse: got %b required 10", i, {de, da}); end
      checks++;
      if ({rh, rl} !== exp) begin errors++; $display("FAIL multu%0d result: got %h required %h", i, {rh, rl}, exp); end
    end
  endtask

  task automatic test_divu();
    logic [W-1:0] ta [2] = '{32'd100, 32'h1234_5678};
    logic [W-1:0] tb [2] = '{32'd7, 32'd0};
    logic st, de, da, ba; int bc; bit gap, hold;
    logic [W-1:0] rh, rl, ha;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      run_op(OP_DIVU, ta[i], tb[i], 0, st, bc, gap, hold, de, da, ba, rh, rl, ha);
      exp = ref_result(OP_DIVU, ta[i], tb[i]);
      checks++;
      if (st !== 1'b1) begin errors++; $display("FAIL divu%0d stall_issue: got %b required 1", i, st); end
      checks++;
      if (bc != 32) begin errors++; $display("FAIL divu%0d busy_cycles: got %0d required 32", i, bc); end
      checks++;
      if ({gap, hold} != 2'b00) begin
        errors++; $display("FAIL divu%0d busy_window gap/hold: got %b required 00", i, {gap, hold});
      end
      checks++;
      if ({de, da} !== 2'b10) begin errors++; $display("FAIL divu%0d done_pulse: got %b required 10", i, {de, da}); end
      checks++;
      if ({rh, rl} !== exp) begin errors++; $display("FAIL divu%0d result: got %h required %h", i, {rh, rl}, exp); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic st; logic [2:0] fl; logic [W-1:0] rh, rl, lo_before;
    lo_before = lo;
    do_move(OP_MTHI, 32'hCAFE_BABE, st, fl, rh, rl);
    checks++;
    if (st !== 1'b0) begin errors++; $display("FAIL mthi stall_issue: got %b required 0", st); end
    checks++;
    if (fl !== 3'b000) begin errors++; $display("FAIL mthi busy/stall/done: got %b required 000", fl); end
    checks++;
    if ({rh, rl} !== {32'hCAFE_BABE, lo_before}) begin
      errors++; $display("FAIL mthi hilo: got %h required %h", {rh, rl}, {32'hCAFE_BABE, lo_before});
    end
    do_move(OP_MTLO, 32'h0BAD_F00D, st, fl, rh, rl);
    checks++;
    if ({st, fl} !== 4'b0000) begin errors++; $display("FAIL mtlo stall/busy/done: got %b required 0000", {st, fl}); end
    checks++;
    if ({rh, rl} !== {32'hCAFE_BABE, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL mtlo hilo: got %h required cafebabe0badf00d", {rh, rl});
    end
  endtask

  task automatic test_ignore_busy();
    logic st, de, da, ba; int bc; bit gap, hold;
    logic [W-1:0] rh, rl, ha;
    run_op(OP_MULTU, 32'd3, 32'd5, 1, st, bc, gap, hold, de, da, ba, rh, rl, ha);
    checks++;
    if (bc != 32 || hold) begin
      errors++; $display("FAIL ignore_busy timing/hold: got cycles=%0d hold=%0b required 32/0", bc, hold);
    end
    checks++;
    if ({rh, rl} !== {32'd0, 32'd15}) begin
      errors++; $display("FAIL ignore_busy result: got %h required 000000000000000f", {rh, rl});
    end
  endtask

  task automatic test_reset_mid();
    logic st, de, da, ba; int bc; bit gap, hold; bit saw_done, saw_busy;
    logic [W-1:0] rh, rl, ha;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, stall, done} !== 3'b000) begin
      errors++; $display("FAIL reset_mid flags: got %b required 000", {busy, stall, done});
    end
    checks++;
    if ({hi, lo} !== '0) begin errors++; $display("FAIL reset_mid hilo: got %h required 0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0; saw_busy = 0;
    repeat (36) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (busy) saw_busy = 1;
    end
    checks++;
    if ({saw_done, saw_busy} != 2'b00) begin
      errors++; $display("FAIL reset_mid aftermath done/busy: got %b required 00", {saw_done, saw_busy});
    end
    run_op(OP_DIVU, 32'd9, 32'd2, 0, st, bc, gap, hold, de, da, ba, rh, rl, ha);
    checks++;
    if ({rh, rl} !== {32'd1, 32'd4} || bc != 32) begin
      errors++; $display("FAIL reset_mid divu: got %h cycles=%0d required 0000000100000004/32", {rh, rl}, bc);
    end
  endtask

  task automatic test_back_to_back();
    logic st, de, da, ba; int bc; bit gap, hold;
    logic [W-1:0] rh, rl, ha;
    logic [2*W-1:0] exp;
    run_op(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 2, st, bc, gap, hold, de, da, ba, rh, rl, ha);
    exp = ref_result(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    checks++;
    if ({rh, rl} !== exp) begin errors++; $display("FAIL b2b first result: got %h required %h", {rh, rl}, exp); end
    checks++;
    if (ha !== exp[2*W-1:W] || ba !== 1'b0 || da !== 1'b0) begin
      errors++; $display("FAIL b2b done_cycle_start hi/busy/done: got %h/%b/%b required %h/0/0",
                         ha, ba, da, exp[2*W-1:W]);
    end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 0, st, bc, gap, hold, de, da, ba, rh, rl, ha);
    exp = ref_result(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    checks++;
    if ({rh, rl} !== exp || bc != 32 || st !== 1'b1) begin
      errors++; $display("FAIL b2b second: got %h cycles=%0d stall=%b required %h/32/1", {rh, rl}, bc, st, exp);
    end
  endtask

  task automatic test_random();
    logic st, de, da, ba; int bc; bit gap, hold;
    logic [W-1:0] rh, rl, ha, ra, rb, mhi, mlo;
    logic [2:0] fl;
    logic [1:0] rop;
    logic [2*W-1:0] exp;
    mhi = hi; mlo = lo;
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick_val();
      rb  = ($urandom_range(0, 7) == 0) ? '0 : pick_val();
      if (rop[1]) begin
        do_move(rop, ra, st, fl, rh, rl);
        if (rop == OP_MTHI) mhi = ra; else mlo = ra;
        checks++;
        if ({rh, rl} !== {mhi, mlo} || {st, fl} !== 4'b0000) begin
          errors++; $display("FAIL rand%0d move op=%0d: got %h flags=%b required %h flags=0000",
                             n, rop, {rh, rl}, {st, fl}, {mhi, mlo});
        end
      end else begin
        run_op(rop, ra, rb, 0, st, bc, gap, hold, de, da, ba, rh, rl, ha);
        exp = ref_result(rop, ra, rb);
        {mhi, mlo} = exp;
        checks++;
        if ({rh, rl} !== exp) begin
          errors++; $display("FAIL rand%0d op=%0d a=%h b=%h: got %h required %h", n, rop, ra, rb, {rh, rl}, exp);
        end
        checks++;
        if (bc != 32 || {gap, hold} != 2'b00 || {de, da} !== 2'b10 || st !== 1'b1) begin
          errors++; $display("FAIL rand%0d timing: got cycles=%0d gap=%0b hold=%0b done=%b%b stall=%b required 32/0/0/10/1",
                             n, bc, gap, hold, de, da, st);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_mthi_mtlo();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
